// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encoding, handshake FSM
// states and the sizing helper for the multiplier iteration counter.
package seq_alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_ANDR = 3'b101;
    localparam logic [2:0] OP_ORR  = 3'b110;
    localparam logic [2:0] OP_XORR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter must hold 0..width-1 with a spare bit of headroom.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/seq_mult.sv
// Iterative WIDTH x WIDTH unsigned shift-add multiplier. Operands are
// captured on start; WIDTH iterations follow. done is high during the final
// iteration and product then carries that iteration's result, so the caller
// can register the finished product on the same edge the last step retires.
module seq_mult
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] prod_d;
    logic [CW-1:0]      cnt_q;
    logic               run_q;
    logic [WIDTH:0]     acc_sum;

    // One shift-add step: lower half holds the remaining multiplier bits,
    // upper half accumulates; the carry of the add shifts back into the top.
    always_comb begin
        acc_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        prod_d  = {acc_sum, prod_q[WIDTH-1:1]};
    end

    assign done    = run_q && (cnt_q == LAST);
    assign product = prod_d;

    // Operand capture on start, then one iteration per cycle until LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else if (start) begin
            mcand_q <= a;
            prod_q  <= {{WIDTH{1'b0}}, b};
            cnt_q   <= '0;
            run_q   <= 1'b1;
        end else if (run_q) begin
            prod_q <= prod_d;
            cnt_q  <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Clocked ALU with valid/ready handshakes on both sides. Single-cycle ops are
// registered straight into the result; MUL is handed to seq_mult and the FSM
// waits for it. One operation is in flight at a time.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2:0]         opcode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out,
    output logic               cout,
    output logic               zero,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] out_q, out_d;
    logic               cout_q, cout_d;
    logic               zero_q, zero_d;

    logic               accept;
    logic               issue;
    logic               mult_start;
    logic               mult_done;
    logic [2*WIDTH-1:0] mult_product;
    logic [2*WIDTH-1:0] alu_out;
    logic               alu_cout;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_diff;

    // Ready in IDLE, or in DONE when the pending result drains this cycle.
    assign in_ready  = rst_n && ((state_q == ST_IDLE) ||
                                 ((state_q == ST_DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_MUL);
    assign out       = out_q;
    assign cout      = cout_q;
    assign zero      = zero_q;

    seq_mult #(
        .WIDTH(WIDTH)
    ) u_mult (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mult_start),
        .a      (a),
        .b      (b),
        .done   (mult_done),
        .product(mult_product)
    );

    // Single-cycle operations; MUL yields nothing here.
    always_comb begin
        add_sum  = {1'b0, a} + {1'b0, b};
        sub_diff = {1'b0, a} - {1'b0, b};
        alu_out  = '0;
        alu_cout = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_out[WIDTH:0] = add_sum;
                alu_cout         = add_sum[WIDTH];
            end
            OP_SUB: begin
                alu_out[WIDTH-1:0] = sub_diff[WIDTH-1:0];
                alu_cout           = sub_diff[WIDTH];
            end
            OP_SHR:  alu_out  = {b >> 1, a >> 1};
            OP_SHL:  alu_out  = {b << 1, a << 1};
            OP_ANDR: alu_cout = (&a) & (&b);
            OP_ORR:  alu_cout = (|a) | (|b);
            OP_XORR: alu_cout = (^a) ^ (^b);
            default: ;
        endcase
    end

    // Next-state and result capture; an accept in DONE follows IDLE rules.
    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        cout_d     = cout_q;
        zero_d     = zero_q;
        mult_start = 1'b0;
        issue      = 1'b0;
        case (state_q)
            ST_IDLE: issue = accept;
            ST_MUL: begin
                if (mult_done) begin
                    out_d   = mult_product;
                    cout_d  = 1'b0;
                    zero_d  = (mult_product == '0);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    issue   = accept;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (issue) begin
            if (opcode == OP_MUL) begin
                mult_start = 1'b1;
                state_d    = ST_MUL;
            end else begin
                out_d   = alu_out;
                cout_d  = alu_cout;
                zero_d  = (alu_out == '0);
                state_d = ST_DONE;
            end
        end
    end

    // State and result registers; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu at WIDTH=8: directed vector table, backpressure and
// mid-MUL reset sequences, then random back-to-back traffic checked against
// an arithmetic reference model.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [2:0]      opcode;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  out;
    logic            cout;
    logic            zero;
    logic            busy;

    int tests = 0;
    int fails = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .opcode   (opcode),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .cout     (cout),
        .zero     (zero),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]     op;
        logic [W-1:0]   av;
        logic [W-1:0]   bv;
        logic [2*W-1:0] exp_out;
        logic           exp_cout;
    } vec_t;

    typedef struct {
        logic [2*W-1:0] o;
        logic           c;
    } res_t;

    vec_t vecs[12];
    res_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end else begin
            $display("[TB] ok %s = 0x%0h", name, got);
        end
    endtask

    // Reference: the opcode rules written as plain integer arithmetic.
    function automatic res_t model(input logic [2:0] op, input int unsigned x, input int unsigned y);
        res_t        r;
        int unsigned v;
        v   = 0;
        r.c = 1'b0;
        case (op)
            3'd0: begin v = x + y; r.c = (v > 255); end
            3'd1: begin v = (x - y) & 'hFF; r.c = (x < y); end
            3'd2: v = x * y;
            3'd3: v = ((y >> 1) << 8) | (x >> 1);
            3'd4: v = (((y << 1) & 'hFF) << 8) | ((x << 1) & 'hFF);
            3'd5: r.c = (x == 'hFF) && (y == 'hFF);
            3'd6: r.c = (x != 0) || (y != 0);
            default: r.c = (($countones(x) + $countones(y)) % 2) == 1;
        endcase
        r.o = v[15:0];
        return r;
    endfunction

    // Present an operation, wait for in_ready, return #1 after the accept edge.
    task automatic send(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        int n;
        opcode   = op;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        n        = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready=0 after 50 cycles, required 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble the inputs: the captured operation must be unaffected.
        opcode   = ~op;
        a        = ~av;
        b        = ~bv;
    endtask

    // Latency counts the cycle after the accept edge as cycle 1.
    task automatic wait_result(output int lat, output int busy_cyc, output int ir_seen);
        lat      = 1;
        busy_cyc = 0;
        ir_seen  = 0;
        while (!out_valid && lat < 50) begin
            if (busy)     busy_cyc++;
            if (in_ready) ir_seen++;
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            tests++;
            fails++;
            $display("FAIL result_timeout: out_valid=0 after %0d cycles, required 1", lat);
        end
    endtask

    initial begin
        int   lat, bcyc, irs, cnt_valid, cnt_stale;
        int   idx, cyc, last_acc;
        logic prev_mul, xi, xo;
        res_t e;

        vecs[0]  = '{OP_ADD,  8'd200, 8'd100, 16'h012C, 1'b1};
        vecs[1]  = '{OP_SUB,  8'd5,   8'd7,   16'h00FE, 1'b1};
        vecs[2]  = '{OP_MUL,  8'd255, 8'd255, 16'hFE01, 1'b0};
        vecs[3]  = '{OP_SHR,  8'h81,  8'h03,  16'h0140, 1'b0};
        vecs[4]  = '{OP_SHL,  8'h81,  8'h03,  16'h0602, 1'b0};
        vecs[5]  = '{OP_ANDR, 8'hFF,  8'hFF,  16'h0000, 1'b1};
        vecs[6]  = '{OP_ORR,  8'h00,  8'h00,  16'h0000, 1'b0};
        vecs[7]  = '{OP_XORR, 8'h01,  8'h00,  16'h0000, 1'b1};
        vecs[8]  = '{OP_SUB,  8'd7,   8'd5,   16'h0002, 1'b0};
        vecs[9]  = '{OP_MUL,  8'd0,   8'd5,   16'h0000, 1'b0};
        vecs[10] = '{OP_ADD,  8'd0,   8'd0,   16'h0000, 1'b0};
        vecs[11] = '{OP_MUL,  8'd3,   8'd4,   16'h000C, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        opcode    = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].op, vecs[i].av, vecs[i].bv);
            wait_result(lat, bcyc, irs);
            chk($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].exp_out));
            chk($sformatf("vec%0d_cout", i), 32'(cout), 32'(vecs[i].exp_cout));
            chk($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].exp_out == 16'h0000));
            chk($sformatf("vec%0d_latency", i), 32'(lat), (vecs[i].op == OP_MUL) ? 32'd9 : 32'd1);
            chk($sformatf("vec%0d_busy_cycles", i), 32'(bcyc), (vecs[i].op == OP_MUL) ? 32'd8 : 32'd0);
            chk($sformatf("vec%0d_in_ready_while_busy", i), 32'(irs), 32'd0);
        end
        @(posedge clk); #1;

        // Backpressure: result held stable, then drain and accept on one edge.
        out_ready = 1'b0;
        send(OP_ADD, 8'd1, 8'd1);
        wait_result(lat, bcyc, irs);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp%0d_out", i), 32'(out), 32'h0002);
            chk($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_on_drain", 32'(in_ready), 32'd1);
        send(OP_XORR, 8'h01, 8'h00);
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_out", 32'(out), 32'h0000);
        chk("bp_next_cout", 32'(cout), 32'd1);
        @(posedge clk); #1;

        // Reset in the middle of a MUL: nothing of it may ever appear.
        send(OP_MUL, 8'd3, 8'd4);
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out", 32'(out), 32'd0);
        chk("midrst_zero", 32'(zero), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt_valid = 0;
        cnt_stale = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) cnt_valid++;
            if (out == 16'h000C) cnt_stale++;
            @(posedge clk); #1;
        end
        chk("midrst_no_result", 32'(cnt_valid), 32'd0);
        chk("midrst_no_stale", 32'(cnt_stale), 32'd0);
        send(OP_ADD, 8'd2, 8'd2);
        wait_result(lat, bcyc, irs);
        chk("midrst_add_out", 32'(out), 32'h0004);
        chk("midrst_add_latency", 32'(lat), 32'd1);
        @(posedge clk); #1;

        // Random back-to-back traffic with in_valid held.
        idx      = 0;
        cyc      = 0;
        last_acc = 0;
        prev_mul = 1'b0;
        opcode   = 3'($urandom_range(0, 7));
        a        = 8'($urandom);
        b        = 8'($urandom);
        in_valid = 1'b1;
        while ((idx < 20 || exp_q.size() != 0) && cyc < 1000) begin
            xo = out_valid;
            xi = in_valid && in_ready;
            if (xo) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rnd_unexpected: out_valid=1 with out=0x%0h, required no result", out);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_out", 32'(out), 32'(e.o));
                    chk("rnd_cout", 32'(cout), 32'(e.c));
                    chk("rnd_zero", 32'(zero), 32'(e.o == 16'h0000));
                end
            end
            if (xi) begin
                exp_q.push_back(model(opcode, int'(a), int'(b)));
            end
            @(posedge clk); #1;
            cyc++;
            if (xi) begin
                if (idx > 0) begin
                    chk("rnd_issue_gap", 32'(cyc - last_acc - 1), prev_mul ? 32'd8 : 32'd0);
                end
                last_acc = cyc;
                prev_mul = (opcode == OP_MUL);
                idx++;
                if (idx < 20) begin
                    opcode = 3'($urandom_range(0, 7));
                    a      = 8'($urandom);
                    b      = 8'($urandom);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        if (cyc >= 1000) begin
            tests++;
            fails++;
            $display("FAIL rnd_timeout: %0d of 20 ops issued, %0d results outstanding", idx, exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
